// File: rtl/mm_bus_arbiter_if.sv
// mm_bus_arbiter_if: per-master request port and the shared peripheral slave port.
interface mm_req_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic              re;
    logic              done;
    logic              stall;
    modport master (output addr, wdata, we, re, input rdata, done, stall);
    modport slave  (input addr, wdata, we, re, output rdata, done, stall);
endinterface

interface mm_slv_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic              re;
    logic              ack;
    modport master (output addr, wdata, we, re, input rdata, ack);
    modport slave  (input addr, wdata, we, re, output rdata, ack);
endinterface

// File: rtl/mm_bus_arbiter.sv
// mm_bus_arbiter: round-robin two-master arbiter for the peripheral bus with
// slave wait states and an access timeout.
module mm_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    mm_req_if.slave     m0,
    mm_req_if.slave     m1,
    mm_slv_if.master    s,
    output logic        err,
    output logic        err_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t     state, nxt;
    logic       r0, r1, gnt, win, wr, last_grant, fin;
    logic [7:0] cnt;
    assign r0 = m0.we | m0.re;
    assign r1 = m1.we | m1.re;
    // m1 wins when alone, or on contention when m0 was served last
    assign gnt = r1 & (~r0 | ~last_grant);
    assign fin = s.ack | (cnt == 8'(TIMEOUT - 1));
    assign m0.stall = r0 & ~m0.done;
    assign m1.stall = r1 & ~m1.done;
    always_comb begin
        nxt = state == IDLE   ? ((r0 | r1) ? ACCESS : IDLE) :
              state == ACCESS ? (fin ? DONE : ACCESS) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win        <= 1'b0;
            wr         <= 1'b0;
            cnt        <= '0;
            s.addr     <= '0;
            s.wdata    <= '0;
            s.we       <= 1'b0;
            s.re       <= 1'b0;
            m0.rdata   <= '0;
            m1.rdata   <= '0;
            m0.done    <= 1'b0;
            m1.done    <= 1'b0;
            err        <= 1'b0;
            err_id     <= 1'b0;
        end else begin
            state   <= nxt;
            m0.done <= 1'b0;
            m1.done <= 1'b0;
            err     <= 1'b0;
            if (state == IDLE && (r0 | r1)) begin
                win     <= gnt;
                wr      <= gnt ? m1.we : m0.we;
                s.addr  <= ADDR_W'(gnt ? m1.addr : m0.addr);
                s.wdata <= DATA_W'(gnt ? m1.wdata : m0.wdata);
                s.we    <= gnt ? m1.we : m0.we;
                s.re    <= gnt ? ~m1.we : ~m0.we;
                cnt     <= '0;
            end
            if (state == ACCESS) begin
                if (fin) begin
                    s.we    <= 1'b0;
                    s.re    <= 1'b0;
                    m0.done <= ~win;
                    m1.done <= win;
                    if (!wr && !win) m0.rdata <= s.ack ? s.rdata : DATA_W'(16'hDEAD);
                    if (!wr && win)  m1.rdata <= s.ack ? s.rdata : DATA_W'(16'hDEAD);
                    if (!s.ack) begin
                        err    <= 1'b1;
                        err_id <= win;
                    end
                end else begin
                    cnt <= cnt + {7'd0, cnt != 8'hFF};
                end
            end
            if (state == DONE) last_grant <= win;
        end
    end
endmodule

// File: doc/mm_bus_arbiter.md
# mm_bus_arbiter

Two-master arbiter for the shared 16-bit memory-mapped peripheral bus. It sits between the CPU's memory-mapped port (`addr`, `wdata`, `mm_we`, `mm_re`, `rdata`) plus one secondary master (DMA or debug loader) and the single peripheral slave port. It serialises accesses with round-robin fairness, tolerates slave wait states through an `s_ack` handshake, and breaks hung transactions with a timeout. A stall output lets the CPU freeze its pipeline while its access is outstanding.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 15, maximum ACCESS cycles before abort; legal range 1..255
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `m0_addr` / `m1_addr`  in  ADDR_W  master address
- `m0_wdata` / `m1_wdata`  in  DATA_W  master write data
- `m0_we` / `m1_we`  in  1  write request
- `m0_re` / `m1_re`  in  1  read request
- `m0_rdata` / `m1_rdata`  out  DATA_W  registered read data per master
- `m0_done` / `m1_done`  out  1  one-cycle completion pulse
- `m0_stall` / `m1_stall`  out  1  request pending and not completing this cycle
- `s_addr`  out  ADDR_W  slave address
- `s_wdata`  out  DATA_W  slave write data
- `s_we`, `s_re`  out  1  slave strobes
- `s_rdata`  in  DATA_W  slave read data, valid with `s_ack`
- `s_ack`  in  1  slave completion
- `err`  out  1  one-cycle timeout pulse
- `err_id`  out  1  master whose access timed out; holds until next timeout

## Operation
- Request: `ri = mi_we | mi_re`. If `we` and `re` are both high, the access is a write.
- A master holds addr, data and strobe until it sees `mi_done`, then may change them at the next edge.
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master not in `last_grant`.
  - On grant, latch the winner's addr, wdata and op into internal registers, clear `cnt`, and go to ACCESS.
- **ACCESS**
  - `s_addr`/`s_wdata` come from the latched registers. Exactly one of `s_we`/`s_re` is high.
  - On `s_ack`: for reads, capture `s_rdata` into the winner's `mi_rdata`. Go to DONE.
  - Otherwise, if `cnt == TIMEOUT-1`, abort. For reads, write `16'hDEAD` to `mi_rdata`. Pulse `err`, set `err_id`, and go to DONE.
  - Otherwise `cnt` increments. `cnt` is 8 bits and saturates.
  - `s_ack` in the terminal cycle counts as success, not timeout.
- **DONE**
  - `s_we`/`s_re` are low.
  - `mi_done` is high for the winner only.
  - `last_grant` is set to the winner.
  - Next state is IDLE.
- Write completion leaves `mi_rdata` unchanged. Each `mi_rdata` holds its value until that master's next read completes.
- `mi_stall = ri & ~mi_done`.
- Dropping a request during ACCESS does not cancel it. The latched transaction completes and `mi_done` still pulses.
- `s_ack` outside ACCESS is ignored.
- `s_addr`/`s_wdata` hold their last latched value outside ACCESS. Slaves must qualify with the strobes.

## Timing
- Reset values:
  - FSM = IDLE
  - `last_grant = 1` (m0 wins the first contention)
  - `cnt`, `s_addr`, `s_wdata`, `m0_rdata`, `m1_rdata` = 0
  - `s_we`, `s_re`, `m0_done`, `m1_done`, `err`, `err_id` = 0
- Uncontended latency with `s_ack` tied high:
  - request seen in IDLE at cycle 0
  - strobe at cycle 1
  - `done` at cycle 2
  - the master's next request can be granted at cycle 3
- Each slave wait state adds one cycle. A timeout access spends exactly TIMEOUT cycles in ACCESS.
- Maximum throughput is one access per 3 cycles. Under continuous contention, grants alternate m0, m1, m0, and so on.
- Outputs are registered, except `mi_stall`, which is combinational from `ri` and `mi_done`.
- Reset asserted mid-transaction aborts immediately to the reset values. There is no `done`; the master re-issues.

## Test plan
- **Single read, m0, `s_ack` tied high, `s_rdata=16'hAAAA`:** `s_re` high in cycle 1, `m0_done` in cycle 2, `m0_rdata=16'hAAAA`, `m0_stall` high in cycles 0–1 only.
- **Simultaneous m0 write and m1 read from reset, held continuously:** grant order m0, m1, m0, m1. Each `done` is spaced 3 cycles apart. The `s_we`/`s_re` pattern alternates.
- **m1 read, `s_ack` delayed 4 cycles, `s_rdata=16'h1234`:** ACCESS lasts 5 cycles, then `m1_done` pulses with `m1_rdata=16'h1234`. `m0_rdata` is unchanged.
- **TIMEOUT=15, m0 read, `s_ack` never asserted:** `err` pulses once, `err_id=0`, `m0_rdata=16'hDEAD`, `m0_done` fires after exactly 15 ACCESS cycles. With `s_ack` on the 15th cycle instead: no `err`, real data returned.
- **`rst_n` pulled low during ACCESS:** all outputs return to their reset values asynchronously with no `done` pulse. After release, m0 wins contention against m1.
- **Request dropped mid-ACCESS and `s_ack` pulsed while IDLE:** the dropped transaction still completes with a `done` pulse. The stray ack causes no state change.
